// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: system-bus master between the cache controller and external memory.
//   A read becomes a LINE_WORDS-beat word burst whose returned words are written into the
//   cache data array as a line fill. A write becomes a single write-through beat.
//   Only one transaction is in flight at a time, and every output is registered.
// Latency with mem_ready tied high: the read's sys_done arrives LINE_WORDS+1 cycles after
//   the request is sampled, together with the last fill. The write's sys_done arrives 2
//   cycles after the request.
// Backpressure: each beat holds mem_req/mem_addr until mem_ready. sys_req is sampled only
//   in IDLE.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   sys_req/sys_rw/sys_addr/sys_wdata request from the cache (SYSaddr stage)
//   sys_busy/sys_done/sys_err         status back to the cache
//   fill_we/fill_idx/fill_data        line-fill write port into the cache data array
//   mem_req/mem_we/mem_addr/mem_wdata beat request to memory; mem_ready/mem_rdata return
// Optional build macro SYSBUS_TIMEOUT_EN: aborts a beat after TIMEOUT_CYCLES cycles
//   without mem_ready and reports the abort on sys_err. Without the macro the controller
//   waits indefinitely and sys_err stays 0.

module sys_bus_ctrl #(
  parameter int ADDRWIDTH      = 32,
  parameter int DATAWIDTH      = 32,
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sys_req,
  input  logic                          sys_rw,
  input  logic [ADDRWIDTH-1:0]          sys_addr,
  input  logic [DATAWIDTH-1:0]          sys_wdata,
  output logic                          sys_busy,
  output logic                          sys_done,
  output logic                          sys_err,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATAWIDTH-1:0]          fill_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDRWIDTH-1:0]          mem_addr,
  output logic [DATAWIDTH-1:0]          mem_wdata,
  input  logic                          mem_ready,
  input  logic [DATAWIDTH-1:0]          mem_rdata
);

  localparam int IDXW = $clog2(LINE_WORDS);
  // Byte-offset bits inside a line. These bits are replaced by the beat offset on reads.
  localparam int OFFW = IDXW + 2;

  // Reject parameter sets that the address arithmetic below cannot handle.
  if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("sys_bus_ctrl: LINE_WORDS must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDRWIDTH-1:0]  addr_q, addr_nxt;
  logic [DATAWIDTH-1:0]  wdata_q, wdata_nxt;
  logic [IDXW-1:0]       beat, beat_nxt;
  logic                  last_beat;
  logic                  tmo;

  // Next-cycle values of the registered outputs.
  logic                  busy_d, done_d, err_d, fill_we_d, mem_req_d, mem_we_d;
  logic [IDXW-1:0]       fill_idx_d;
  logic [DATAWIDTH-1:0]  fill_data_d, mem_wdata_d;
  logic [ADDRWIDTH-1:0]  mem_addr_d;

  assign last_beat = (beat == IDXW'(LINE_WORDS - 1));

  // Request fields are captured in IDLE. After that, only the latched copies are used.
  assign addr_nxt  = (state == IDLE) ? sys_addr  : addr_q;
  assign wdata_nxt = (state == IDLE) ? sys_wdata : wdata_q;

`ifdef SYSBUS_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WW-1:0] wcnt;

  // mem_req is high exactly while in RD/WR. The abort fires on the cycle in which the
  // counter would reach TIMEOUT_CYCLES, so mem_req is high for TIMEOUT_CYCLES cycles.
  assign tmo = (state == RD || state == WR) && !mem_ready &&
               (wcnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (state == IDLE || state == DONE || mem_ready) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // State register, latched request, and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sys_busy  <= 1'b0;
      sys_done  <= 1'b0;
      sys_err   <= 1'b0;
      fill_we   <= 1'b0;
      fill_idx  <= '0;
      fill_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      sys_busy  <= busy_d;
      sys_done  <= done_d;
      sys_err   <= err_d;
      fill_we   <= fill_we_d;
      fill_idx  <= fill_idx_d;
      fill_data <= fill_data_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (sys_req) state_nxt = sys_rw ? WR : RD;
      end
      RD: begin
        if (mem_ready) begin
          // The counter stops at LINE_WORDS-1. It returns to 0 only in IDLE.
          if (last_beat) state_nxt = DONE;
          else           beat_nxt  = beat + 1'b1;
        end else if (tmo) begin
          state_nxt = DONE;
        end
      end
      WR: begin
        if (mem_ready || tmo) state_nxt = DONE;
      end
      default: state_nxt = IDLE;  // DONE lasts exactly one cycle
    endcase
  end

  // Output logic. Each output is derived from the transition about to be taken, so the
  // registered value lines up with the state it belongs to.
  always_comb begin
    busy_d      = (state_nxt != IDLE);
    done_d      = (state_nxt == DONE);
    err_d       = (state_nxt == DONE) && tmo;
    mem_req_d   = (state_nxt == RD) || (state_nxt == WR);
    mem_we_d    = (state_nxt == WR);
    fill_we_d   = (state == RD) && mem_ready;
    fill_idx_d  = fill_idx;
    fill_data_d = fill_data;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if (fill_we_d) begin
      fill_idx_d  = beat;
      fill_data_d = mem_rdata;
    end
    if (state_nxt == RD) begin
      // Line-aligned base plus the beat offset. Input alignment bits are discarded.
      mem_addr_d = {addr_nxt[ADDRWIDTH-1:OFFW], beat_nxt, 2'b00};
    end else if (state_nxt == WR) begin
      mem_addr_d  = addr_nxt;
      mem_wdata_d = wdata_nxt;
    end
  end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
module tb_sys_bus_ctrl;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sys_req, sys_rw;
  logic [31:0] sys_addr, sys_wdata;
  logic        sys_busy, sys_done, sys_err;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int nchk  = 0;
  int nfail = 0;

  sys_bus_ctrl #(.ADDRWIDTH(32), .DATAWIDTH(32), .LINE_WORDS(LW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sys_req(sys_req), .sys_rw(sys_rw), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_busy(sys_busy), .sys_done(sys_done), .sys_err(sys_err),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},      sys_busy,  0);
    chk({tag, ".done"},      sys_done,  0);
    chk({tag, ".err"},       sys_err,   0);
    chk({tag, ".fill_we"},   fill_we,   0);
    chk({tag, ".fill_idx"},  fill_idx,  0);
    chk({tag, ".fill_data"}, fill_data, 0);
    chk({tag, ".mem_req"},   mem_req,   0);
    chk({tag, ".mem_we"},    mem_we,    0);
    chk({tag, ".mem_addr"},  mem_addr,  0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // Runs one transaction and checks it against a beat/fill model. The task is entered and
  // exited at a negedge. mode selects the mem_ready pattern: 0 = always ready,
  // 1 = ready on every 3rd request cycle, 2 = random, 3 = never ready.
  // If abort_idx >= 0, reset is asserted once the fill with that index has been observed.
  task automatic run_txn(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                         input int mode, input bit hold, input int abort_idx,
                         input bit exp_err);
    int          exp_idx[$];
    logic [31:0] exp_dat[$];
    int          beats = 0, n = 0, nreq = 0, last_rdy = -1, nfill = 0;
    bit          done = 0, r;
    logic [31:0] exp_addr;
    sys_req = 1'b1; sys_rw = rw; sys_addr = addr; sys_wdata = wd; mem_ready = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      // Only the latched copies may matter from here on.
      if (n == 1) begin sys_addr = $urandom; sys_wdata = $urandom; sys_rw = 1'($urandom); end
      chk("err_without_done", sys_err & ~sys_done, 0);
      if (fill_we) begin
        if (exp_idx.size() == 0) chk("fill_unexpected", 1, 0);
        else begin
          chk("fill_idx", fill_idx, exp_idx.pop_front());
          chk("fill_data", fill_data, exp_dat.pop_front());
          nfill++;
        end
        if (abort_idx >= 0 && nfill == abort_idx + 1) begin
          rst_n = 1'b0;
          mem_ready = 1'b0;
          #1 chk_all_zero("async_reset");
          repeat (3) begin
            @(negedge clk);
            chk("reset_no_done", sys_done, 0);
            chk("reset_no_fill", fill_we, 0);
            chk("reset_no_req", mem_req, 0);
          end
          sys_req = 1'b0;
          rst_n = 1'b1;
          return;
        end
      end
      if (sys_done) begin
        done = 1;
        chk("done_busy", sys_busy, 1);
        chk("done_mem_req", mem_req, 0);
        chk("done_err", sys_err, exp_err);
        chk("fill_count", nfill, rw ? 0 : beats);
        chk("fills_pending", exp_idx.size(), 0);
        if (exp_err) begin
          chk("tmo_req_cycles", nreq, 8);
          chk("tmo_done_cycle", n, nreq + 1);
        end else begin
          chk("beat_count", beats, rw ? 1 : LW);
          chk("done_after_last_ready", n, last_rdy + 1);
          if (mode == 0) chk("done_latency", n, rw ? 2 : LW + 1);
        end
        if (!hold) sys_req = 1'b0;
        mem_ready = 1'($urandom);  // ignored in DONE
      end else begin
        chk("busy", sys_busy, 1);
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, rw);
        exp_addr = rw ? addr : ((addr & ~32'hF) + 32'(beats * 4));
        chk("mem_addr", mem_addr, exp_addr);
        if (rw) chk("mem_wdata", mem_wdata, wd);
        nreq++;
        case (mode)
          0:       r = 1;
          1:       r = (nreq % 3 == 0);
          2:       r = 1'($urandom);
          default: r = 0;
        endcase
        mem_ready = r;
        mem_rdata = $urandom;
        if (r) begin
          if (!rw) begin exp_idx.push_back(beats); exp_dat.push_back(mem_rdata); end
          beats++;
          last_rdy = n;
        end
      end
    end
    if (!done) chk("done_never_seen", 0, 1);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    chk("idle_busy", sys_busy, 0);
    chk("idle_done", sys_done, 0);
    chk("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sys_req = 0; sys_rw = 0; sys_addr = 0; sys_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(0, 32'h0000_1230, 32'h0, 0, 0, -1, 0);        // read burst, always ready
    idle_gap();
    run_txn(1, 32'h0000_4008, 32'hDEAD_BEEF, 1, 0, -1, 0); // write with wait states
    idle_gap();
    run_txn(0, 32'h0000_2007, 32'h0, 1, 0, -1, 0);        // misaligned read, wait states
    idle_gap();
    run_txn(0, 32'h0000_5550, 32'h0, 0, 1, -1, 0);        // held request
    idle_gap();                                            // IDLE cycle even with sys_req high
    run_txn(1, 32'h0000_6664, 32'h1234_5678, 0, 0, -1, 0);
    idle_gap();
    run_txn(0, 32'h0000_7770, 32'h0, 0, 0, 1, 0);         // reset after fill index 1
    @(negedge clk);
    run_txn(0, 32'h0000_8880, 32'h0, 0, 0, -1, 0);        // restarts at beat 0
    idle_gap();
`ifdef SYSBUS_TIMEOUT_EN
    run_txn(0, 32'h0000_9990, 32'h0, 3, 0, -1, 1);        // never ready -> timeout abort
    idle_gap();
`endif

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      bit h;
      h = ($urandom_range(0, 4) == 0);
      run_txn(1'($urandom), $urandom, $urandom, $urandom_range(0, 2), h, -1, 0);
      idle_gap();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
